// File: rtl/prng_arbiter.sv
// prng_arbiter: round-robin shared 16-bit LFSR random-byte server with whitening.
// Ports: clk, rst_n (async, active-low); seed_load/seed_data/seed_ready reseed the LFSR
// in IDLE; req/ack/gnt/rnd_valid/rnd_data form the per-requester byte handshake;
// busy flags SHIFT/PRESENT; lfsr_state exposes the LFSR for debug.
module prng_arbiter #(
   parameter int NREQ   = 4,
   parameter int SHIFTS = 8
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            seed_load,
   input  logic [15:0]     seed_data,
   output logic            seed_ready,
   input  logic [NREQ-1:0] req,
   input  logic            ack,
   output logic [NREQ-1:0] gnt,
   output logic            rnd_valid,
   output logic [7:0]      rnd_data,
   output logic            busy,
   output logic [15:0]     lfsr_state
);
   localparam int IW = $clog2(NREQ);
   localparam int CW = $clog2(SHIFTS + 1);
   localparam logic [15:0] SEED0 = 16'hACE1;
   typedef enum logic [1:0] {IDLE, SHIFT, PRESENT} state_t;
   state_t state, state_nx;
   logic [15:0] lfsr, lfsr_step;
   logic [IW-1:0] idx, last, pick;
   logic [CW-1:0] cnt;
   logic found, last_shift, done;
   function automatic logic [7:0] whiten(input logic [15:0] s);
      return {s[14:8], s[15]} ^ {s[0], s[7:1]};
   endfunction
   assign lfsr_step  = {lfsr[14:0], lfsr[15] ^ lfsr[14] ^ lfsr[12] ^ lfsr[3]};
   assign last_shift = cnt == CW'(SHIFTS - 1);
   // a withdrawn request ends the transaction exactly like an ack
   assign done       = ack || !req[idx];
   // round-robin scan starting just after the last served requester
   always_comb begin
      int j;
      pick  = '0;
      found = 1'b0;
      for (int i = 1; i <= NREQ; i++) begin
         j = (int'(last) + i) % NREQ;
         if (!found && req[j]) begin
            pick  = IW'(j);
            found = 1'b1;
         end
      end
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    state_nx = (!seed_load && found) ? SHIFT : IDLE;
         SHIFT:   state_nx = last_shift ? PRESENT : SHIFT;
         PRESENT: state_nx = done ? IDLE : PRESENT;
         default: state_nx = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         lfsr     <= SEED0;
         idx      <= '0;
         last     <= IW'(NREQ - 1);
         cnt      <= '0;
         rnd_data <= '0;
      end else begin
         if (state == IDLE && seed_load) lfsr <= (seed_data == 16'h0000) ? SEED0 : seed_data;
         else if (state == SHIFT)         lfsr <= lfsr_step;
         if (state == IDLE && !seed_load && found) begin
            idx <= pick;
            cnt <= '0;
         end
         if (state == SHIFT) cnt <= cnt + CW'(1);
         if (state == SHIFT && last_shift) rnd_data <= whiten(lfsr_step);
         if (state == PRESENT && done) last <= idx;
      end
   always_comb begin
      seed_ready = state == IDLE;
      busy       = state != IDLE;
      rnd_valid  = state == PRESENT;
      gnt        = rnd_valid ? {{(NREQ-1){1'b0}}, 1'b1} << idx : '0;
      lfsr_state = lfsr;
   end
endmodule
